sbox_responder: RTL and testbench
=================================

# sbox_responder

S-box lookup server for the AES datapath. It answers the SubBytes engine's byte requests over the address/data flag handshake and returns the forward S-box value, or the inverse S-box value for decryption. The value is computed arithmetically rather than stored: a multicycle GF(2^8) inversion by repeated square-and-multiply, wrapped by the affine transforms. One request is in flight at a time. The block sits next to the AES round logic and is shared by its SubBytes/InvSubBytes sequencer.

## Interface

- EN_INVERSE, 1, when 0 the `inverse` input is ignored and only forward S-box values are returned
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low (low = reset)
- sbox_rqst_addr  in  8  byte to substitute; sampled only on request capture
- flag_address_sent  in  1  initiator request valid
- inverse  in  1  1 = InvSubBytes; sampled together with the address
- data_ack  in  1  initiator has consumed `sbox_read_data`
- addr_ack  out  1  one-cycle pulse: request captured
- flag_data_sent  out  1  result valid; held until `data_ack`
- sbox_read_data  out  8  substituted byte; registered
- busy  out  1  high from capture until the handshake completes

## Operation

- FSM states:
  - IDLE: waits for a request. On a clock edge with flag_address_sent=1, latches the request, sets counter=0, pulses addr_ack and goes to EXP.
  - EXP: runs for counter values 0..6, then goes to RESP.
  - RESP: holds the result until data_ack is sampled high.
- Capture:
  - If inverse=1 and EN_INVERSE=1, x = rotl(a,1)^rotl(a,3)^rotl(a,6)^0x05; otherwise x = a.
  - The latched mode bit is m = inverse & EN_INVERSE.
  - p is initialised to x.
- EXP, counter 0..5: p <= sq(p)·x, which leaves p = x^127 after six steps.
- EXP, counter 6: p <= sq(p), which gives p = x^254 = x^-1.
  - x=0 naturally yields 0; no special case is needed.
- GF rules:
  - Multiply in GF(2^8) modulo 0x11B, combinational, 8-bit result.
  - sq(p) is the same multiplier with both operands equal to p.
- Leaving EXP:
  - sbox_read_data <= m ? p : p^rotl(p,1)^rotl(p,2)^rotl(p,3)^rotl(p,4)^0x63.
  - flag_data_sent <= 1, go to RESP.
- RESP:
  - sbox_read_data and flag_data_sent are held stable.
  - On data_ack=1: flag_data_sent <= 0, go to IDLE.
- Requests are ignored outside IDLE.
  - The initiator must drop flag_address_sent after it sees addr_ack.
  - If it is still high in IDLE, it is treated as a new request.
- data_ack outside RESP has no effect.
- busy = (state != IDLE).

## Timing

- Reset (rst=0 sampled at an edge):
  - state IDLE, counter 0, p 0.
  - addr_ack=0, flag_data_sent=0, sbox_read_data=0x00, busy=0.
- Reset mid-operation (EXP or RESP) discards the request and no result is delivered.
- Request sampled at edge T0:
  - addr_ack=1 and busy=1 during cycle T0..T1.
  - addr_ack=0 from T1.
- EXP runs on edges T1..T7.
- flag_data_sent=1 with valid data after edge T8: fixed latency of 8 cycles from capture to data valid.
- data_ack sampled high at edge Tn:
  - flag_data_sent=0 and busy=0 after Tn.
  - sbox_read_data keeps its last value.
- Earliest next capture is edge Tn+1, so the minimum period per lookup is 10 cycles when data_ack is returned immediately.
- flag_address_sent and data_ack both high in RESP: the data handshake completes and the request is not captured. It is captured at the next edge if still high.

## Test plan

- Forward spot values, inverse=0: 0x00->0x63, 0x01->0x7C, 0x53->0xED, 0xFF->0x16.
  - flag_data_sent rises exactly 8 cycles after capture.
  - addr_ack is a single-cycle pulse.
- Inverse values, inverse=1: 0x63->0x00, 0xED->0x53, 0x16->0xFF, 0x7C->0x01.
  - With EN_INVERSE=0, inverse=1 on 0x53 returns 0xED.
- Exhaustive round trip: all 256 bytes a, forward then inverse. Each must return a; forward results must be a permutation with no fixed points.
- Back-pressure: hold data_ack low for 20 cycles.
  - flag_data_sent and data stay constant, busy=1.
  - flag_address_sent pulses during this time are ignored (no addr_ack).
  - data_ack then completes the lookup.
- Reset mid-EXP: drop rst at T4.
  - Outputs go to 0 after the reset edge and no flag_data_sent appears.
  - A new request 0x53 then yields 0xED normally.
- Simultaneous events: data_ack and flag_address_sent both high in RESP.
  - The first handshake completes with no capture in that cycle.
  - The next request is captured one cycle later; back-to-back requests give a 10-cycle period.

Source files
------------

// File: rtl/sbox_responder_if.sv
// Request/response handshake between the SubBytes sequencer (master) and
// the S-box lookup server (slave).
interface sbox_responder_if;
  logic [7:0] sbox_rqst_addr;
  logic       flag_address_sent;
  logic       inverse;
  logic       data_ack;
  logic       addr_ack;
  logic       flag_data_sent;
  logic [7:0] sbox_read_data;
  logic       busy;

  modport master (
    output sbox_rqst_addr, flag_address_sent, inverse, data_ack,
    input  addr_ack, flag_data_sent, sbox_read_data, busy
  );

  modport slave (
    input  sbox_rqst_addr, flag_address_sent, inverse, data_ack,
    output addr_ack, flag_data_sent, sbox_read_data, busy
  );
endinterface

// File: rtl/sbox_responder.sv
// AES S-box server: GF(2^8) inversion by square-and-multiply (x^254),
// wrapped by the forward or inverse affine transform.
//
//   state | meaning
//   IDLE  | waiting for flag_address_sent; capture pulses addr_ack
//   EXP   | cnt 0..5: p = p^2*x, cnt 6: p = p^2, cnt 7: affine + publish
//   RESP  | result held until data_ack
module sbox_responder #(
  parameter bit EN_INVERSE = 1'b1
) (
  input logic         clk,
  input logic         rst,
  sbox_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXP, RESP} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1B) : {t[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] p);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
             ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;
  logic [7:0] x_q, x_d;
  logic       m_q, m_d;
  logic [7:0] data_q, data_d;
  logic       flag_q, flag_d;
  logic       ack_q, ack_d;
  logic [7:0] sq_p;
  logic       cap_m;

  assign sq_p  = gf_mul(p_q, p_q);
  assign cap_m = bus.inverse & EN_INVERSE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
      x_q     <= 8'h00;
      m_q     <= 1'b0;
      data_q  <= 8'h00;
      flag_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      x_q     <= x_d;
      m_q     <= m_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    x_d     = x_q;
    m_d     = m_q;
    data_d  = data_q;
    flag_d  = flag_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flag_address_sent) begin
          x_d     = cap_m ? inv_affine(bus.sbox_rqst_addr) : bus.sbox_rqst_addr;
          p_d     = x_d;
          m_d     = cap_m;
          cnt_d   = 3'd0;
          ack_d   = 1'b1;
          state_d = EXP;
        end
      end
      EXP: begin
        // x = 0 falls out as 0 from the exponentiation itself
        if (cnt_q == 3'd7) begin
          data_d  = m_q ? p_q : fwd_affine(p_q);
          flag_d  = 1'b1;
          state_d = RESP;
        end else begin
          p_d   = (cnt_q == 3'd6) ? sq_p : gf_mul(sq_p, x_q);
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (bus.data_ack) begin
          flag_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.addr_ack       = ack_q;
  assign bus.flag_data_sent = flag_q;
  assign bus.sbox_read_data = data_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_responder.sv
// Self-checking bench for sbox_responder: table-based S-box model, per-cycle
// output comparison, and directed handshake/boundary scenarios.
module tb_sbox_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sbox_responder_if bus ();
  sbox_responder_if bus_f ();

  assign bus_f.sbox_rqst_addr    = bus.sbox_rqst_addr;
  assign bus_f.flag_address_sent = bus.flag_address_sent;
  assign bus_f.inverse           = bus.inverse;
  assign bus_f.data_ack          = bus.data_ack;

  sbox_responder #(.EN_INVERSE(1'b1)) dut   (.clk(clk), .rst(rst), .bus(bus));
  sbox_responder #(.EN_INVERSE(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

  int n_pass = 0;
  int n_total = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_tbl [256];
  logic [7:0] inv_tbl  [256];

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] pr;
    pr = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) pr = pr ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--)
      if (pr[i]) pr = pr ^ (16'h011B << (i - 8));
    return pr[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] x, y, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      y = 8'h00;
      for (int j = 1; j < 256; j++)
        if (m_mul(x, 8'(j)) == 8'h01) y = 8'(j);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      sbox_tbl[i] = s;
      inv_tbl[s]  = x;
    end
  endtask

  // Transaction-level expectation: idle / computing (8 edges) / holding.
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         m_busy = 1'b0, m_flag = 1'b0, m_ack = 1'b0;
  int         m_age = 0;
  logic [7:0] m_data = 8'h00, m_data_f = 8'h00;
  logic [7:0] m_pend = 8'h00, m_pend_f = 8'h00;

  always @(posedge clk) begin
    cyc++;
    chk_en = 1'b1;
    if (!rst) begin
      m_busy = 1'b0; m_flag = 1'b0; m_ack = 1'b0; m_age = 0;
      m_data = 8'h00; m_data_f = 8'h00;
    end else begin
      m_ack = 1'b0;
      if (!m_busy) begin
        if (bus.flag_address_sent) begin
          m_busy   = 1'b1;
          m_ack    = 1'b1;
          m_age    = 0;
          m_pend   = bus.inverse ? inv_tbl[bus.sbox_rqst_addr] : sbox_tbl[bus.sbox_rqst_addr];
          m_pend_f = sbox_tbl[bus.sbox_rqst_addr];
        end
      end else if (m_flag) begin
        if (bus.data_ack) begin
          m_flag = 1'b0;
          m_busy = 1'b0;
        end
      end else begin
        m_age++;
        if (m_age == 8) begin
          m_flag   = 1'b1;
          m_data   = m_pend;
          m_data_f = m_pend_f;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("cyc_addr_ack", bus.addr_ack, m_ack);
      check1("cyc_flag", bus.flag_data_sent, m_flag);
      check1("cyc_busy", bus.busy, m_busy);
      check8("cyc_data", bus.sbox_read_data, m_data);
      check1("cyc_flag_en0", bus_f.flag_data_sent, m_flag);
      check8("cyc_data_en0", bus_f.sbox_read_data, m_data_f);
    end
  end

  // ---------------- stimulus ----------------
  int cap_cyc = 0;

  task automatic issue(input logic [7:0] a, input logic inv);
    int n;
    bus.sbox_rqst_addr    = a;
    bus.inverse           = inv;
    bus.flag_address_sent = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.addr_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.flag_address_sent = 1'b0;
    cap_cyc = cyc;
    check1("capture", bus.addr_ack, 1'b1);
    @(negedge clk);
    check1("addr_ack_pulse", bus.addr_ack, 1'b0);
  endtask

  task automatic wait_data(output logic [7:0] d, output int lat);
    int n;
    n = 0;
    while (!bus.flag_data_sent && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.flag_data_sent) check1("data_timeout", 1'b0, 1'b1);
    d   = bus.sbox_read_data;
    lat = cyc - cap_cyc;
  endtask

  task automatic ack();
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a, input logic inv, output logic [7:0] d, output int lat);
    issue(a, inv);
    wait_data(d, lat);
    ack();
  endtask

  logic [7:0] spot_a   [8] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h63, 8'hED, 8'h16, 8'h7C};
  logic       spot_inv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] spot_exp [8] = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'h00, 8'h53, 8'hFF, 8'h01};

  initial begin
    logic [7:0] d, d2, held;
    int lat, first_cap, seen_cnt;
    bit seen [256];

    bus.sbox_rqst_addr    = 8'h00;
    bus.inverse           = 1'b0;
    bus.flag_address_sent = 1'b0;
    bus.data_ack          = 1'b0;
    build_tables();

    check8("model_fwd_00", sbox_tbl[8'h00], 8'h63);
    check8("model_fwd_53", sbox_tbl[8'h53], 8'hED);
    check8("model_fwd_FF", sbox_tbl[8'hFF], 8'h16);
    check8("model_inv_7C", inv_tbl[8'h7C], 8'h01);

    repeat (3) @(negedge clk);
    check1("rst_addr_ack", bus.addr_ack, 1'b0);
    check1("rst_flag", bus.flag_data_sent, 1'b0);
    check8("rst_data", bus.sbox_read_data, 8'h00);
    check1("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      lookup(spot_a[i], spot_inv[i], d, lat);
      check8("spot_value", d, spot_exp[i]);
      check_int("spot_latency", lat, 8);
    end
    lookup(8'h53, 1'b1, d, lat);
    check8("en0_inverse_ignored", bus_f.sbox_read_data, 8'hED);

    seen_cnt = 0;
    for (int a = 0; a < 256; a++) begin
      lookup(8'(a), 1'b0, d, lat);
      lookup(d, 1'b1, d2, lat);
      check8("round_trip", d2, 8'(a));
      check1("no_fixed_point", (d == 8'(a)), 1'b0);
      if (!seen[d]) seen_cnt++;
      seen[d] = 1'b1;
    end
    check_int("permutation", seen_cnt, 256);

    // back-pressure with ignored request pulses
    issue(8'h53, 1'b0);
    wait_data(held, lat);
    check8("bp_value", held, 8'hED);
    for (int i = 0; i < 20; i++) begin
      bus.sbox_rqst_addr    = 8'h00;
      bus.flag_address_sent = (i == 5 || i == 12);
      @(negedge clk);
      check1("bp_flag", bus.flag_data_sent, 1'b1);
      check8("bp_data", bus.sbox_read_data, held);
      check1("bp_busy", bus.busy, 1'b1);
      check1("bp_no_ack", bus.addr_ack, 1'b0);
    end
    bus.flag_address_sent = 1'b0;
    ack();
    check1("bp_done_flag", bus.flag_data_sent, 1'b0);
    check1("bp_done_busy", bus.busy, 1'b0);
    check8("bp_data_kept", bus.sbox_read_data, 8'hED);

    // reset while in EXP, sampled at T4
    issue(8'h01, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("mid_rst_busy", bus.busy, 1'b0);
    check1("mid_rst_flag", bus.flag_data_sent, 1'b0);
    check8("mid_rst_data", bus.sbox_read_data, 8'h00);
    check1("mid_rst_ack", bus.addr_ack, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check1("mid_rst_no_result", bus.flag_data_sent, 1'b0);
    end
    lookup(8'h53, 1'b0, d, lat);
    check8("after_rst_value", d, 8'hED);

    // data_ack and a new request in the same RESP cycle
    issue(8'h01, 1'b0);
    first_cap = cap_cyc;
    wait_data(d, lat);
    check8("sim_first", d, 8'h7C);
    bus.sbox_rqst_addr    = 8'hFF;
    bus.inverse           = 1'b0;
    bus.flag_address_sent = 1'b1;
    bus.data_ack          = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    check1("sim_no_capture", bus.addr_ack, 1'b0);
    check1("sim_idle", bus.busy, 1'b0);
    check1("sim_flag_low", bus.flag_data_sent, 1'b0);
    @(negedge clk);
    bus.flag_address_sent = 1'b0;
    check1("sim_capture", bus.addr_ack, 1'b1);
    check_int("sim_period", cyc - first_cap, 10);
    cap_cyc = cyc;
    wait_data(d, lat);
    check8("sim_second", d, 8'h16);
    check_int("sim_latency", lat, 8);
    ack();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
